// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM states, grant
// encoding and the instruction word width.
package mem_port_arbiter_pkg;

    localparam int LEN_INST = 32;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } arb_gnt_t;

    function automatic int lat_cnt_w(input int lat);
        return $clog2(lat) + 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_lat_cnt.sv
// Access-latency counter: loads the remaining BUSY cycles at grant and
// flags the final cycle of the access.
module mem_port_arbiter_lat_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency unified memory between the fetch and data
// ports, holding results until the pipeline advances; drives the global stall.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = LEN_INST,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CW = lat_cnt_w(MEM_LAT);

    arb_state_t state;
    arb_gnt_t   gnt;
    logic       we_r;
    logic       dm_req;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_zero;

    assign dm_req   = dm_rd | dm_wr;
    assign stall    = (if_req & ~if_done) | (dm_req & ~dm_done);
    assign cnt_load = (state == ARB_IDLE) & stall;
    assign cnt_dec  = (state == ARB_BUSY) & ~cnt_zero;

    // Gating with rst lets a reset in the last BUSY cycle suppress the commit.
    assign mem_we = mem_en & we_r & cnt_zero & rst;

    mem_port_arbiter_lat_cnt #(.W(CW)) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (CW'(MEM_LAT - 1)),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ARB_IDLE;
            gnt       <= GNT_I;
            we_r      <= 1'b0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (!stall) begin
                if_done <= 1'b0;
                dm_done <= 1'b0;
            end
            case (state)
                ARB_IDLE: begin
                    if (stall) begin
                        state  <= ARB_BUSY;
                        mem_en <= 1'b1;
                        // Data wins a tie so the older instruction drains first.
                        if (dm_req & ~dm_done) begin
                            gnt       <= GNT_D;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            we_r      <= dm_wr;
                        end else begin
                            gnt      <= GNT_I;
                            mem_addr <= if_addr;
                            we_r     <= 1'b0;
                        end
                    end
                end
                ARB_BUSY: begin
                    if (cnt_zero) begin
                        state  <= ARB_IDLE;
                        mem_en <= 1'b0;
                        we_r   <= 1'b0;
                        if (gnt == GNT_D) begin
                            dm_done <= 1'b1;
                            if (!we_r)
                                dm_rdata <= mem_rdata;
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cycle checks, then random pipeline
// traffic scored against a transaction-level model of the shared memory.
module tb_mem_port_arbiter;

    localparam int MEM_LAT = 2;
    localparam int LIMIT   = 4 * (MEM_LAT + 1) + 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_rd, dm_wr;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        if_done, dm_done, stall, mem_en, mem_we;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .stall(stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory behind the arbiter: unwritten words read as addr ^ 0xFFFF0000.
    logic [31:0] dut_mem [logic [31:0]];
    always @(posedge clk) if (mem_we) dut_mem[mem_addr] = mem_wdata;
    always @(negedge clk)
        mem_rdata <= dut_mem.exists(mem_addr) ? dut_mem[mem_addr] : (mem_addr ^ 32'hFFFF0000);

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one transaction = the accesses of one pipeline step.
    typedef struct {
        bit          has_if;
        bit          has_dm;
        bit          dm_is_rd;
        logic [31:0] if_data;
        logic [31:0] dm_data;
        int          stalls;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    int          n_stores = 0;
    int          we_cnt   = 0;
    int          st_cnt   = 0;
    bit          mon_en   = 0;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'hFFFF0000);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_we) we_cnt++;
            if (stall) st_cnt++;
            else if (if_req | dm_rd | dm_wr) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL scoreboard_underflow: completion with no expected entry at %0t", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("stall_cycles", st_cnt, e.stalls);
                    chk("if_done", {31'd0, if_done}, {31'd0, e.has_if});
                    chk("dm_done", {31'd0, dm_done}, {31'd0, e.has_dm});
                    if (e.has_if) chk("if_rdata", if_rdata, e.if_data);
                    if (e.dm_is_rd) chk("dm_rdata", dm_rdata, e.dm_data);
                end
                st_cnt = 0;
            end
        end
    end

    task automatic idle_inputs();
        if_req = 0; dm_rd = 0; dm_wr = 0;
    endtask

    // Waits at negedges until the stall drops; returns on the completion sample.
    task automatic wait_done(input string nm);
        int k;
        for (k = 0; k < LIMIT; k++) begin
            @(negedge clk);
            if (!stall) break;
        end
        if (k == LIMIT) begin
            n_chk++; n_fail++;
            $display("FAIL %s_timeout: stall still %b after %0d cycles", nm, stall, LIMIT);
        end
    endtask

    task automatic issue(input bit fi, input bit rd, input bit wr,
                         input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd);
        exp_t e;
        e.has_if   = fi;
        e.has_dm   = rd | wr;
        e.dm_is_rd = rd & ~wr;
        e.dm_data  = '0;
        if (wr) begin ref_mem[da] = wd; n_stores++; end
        else if (rd) e.dm_data = ref_rd(da);
        e.if_data = fi ? ref_rd(ia) : '0;
        e.stalls  = (int'(fi) + int'(rd | wr)) * (MEM_LAT + 1);
        exp_q.push_back(e);
        if_req = fi; if_addr = ia; dm_rd = rd; dm_wr = wr; dm_addr = da; dm_wdata = wd;
        wait_done("rand");
    endtask

    task automatic dir_rd(input logic [31:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        dm_rd = 1; dm_addr = a;
        wait_done("readback");
        chk("readback_done", {31'd0, dm_done}, 32'd1);
        d = dm_rdata;
        #1 idle_inputs();
    endtask

    logic [31:0] rd_val;

    initial begin
        rst = 0; idle_inputs();
        if_req = 1; if_addr = 32'h40; dm_addr = '0; dm_wdata = '0;

        // Reset holds everything at zero even with a fetch pending.
        repeat (3) @(negedge clk);
        chk("rst_if_done", {31'd0, if_done}, 0);
        chk("rst_dm_done", {31'd0, dm_done}, 0);
        chk("rst_rdata", if_rdata | dm_rdata, 0);
        chk("rst_mem_en_we", {30'd0, mem_en, mem_we}, 0);
        chk("rst_mem_addr", mem_addr | mem_wdata, 0);

        // Release; fetch 0x40 is granted at the end of this cycle.
        @(posedge clk); #1 rst = 1;
        @(negedge clk); chk("t0_mem_en", {31'd0, mem_en}, 0);
        @(negedge clk); chk("t1_mem_en", {31'd0, mem_en}, 1);
                        chk("t1_mem_addr", mem_addr, 32'h40);
        @(negedge clk); chk("t2_mem_en", {31'd0, mem_en}, 1);
        @(negedge clk); chk("t3_if_done", {31'd0, if_done}, 1);
                        chk("t3_if_rdata", if_rdata, 32'hFFFF0040);
                        chk("t3_stall", {31'd0, stall}, 0);
        #1 idle_inputs();
        @(negedge clk); chk("t4_if_done_clr", {31'd0, if_done}, 0);

        // Simultaneous fetch and load: data first.
        @(posedge clk); #1;
        if_req = 1; if_addr = 32'h44; dm_rd = 1; dm_addr = 32'h100;
        @(negedge clk); chk("both_t0_stall", {31'd0, stall}, 1);
        @(negedge clk); chk("both_t1_addr", mem_addr, 32'h100);
        repeat (2) @(negedge clk);
        chk("both_t3_dm_done", {31'd0, dm_done}, 1);
        chk("both_t3_dm_rdata", dm_rdata, 32'hFFFF0100);
        chk("both_t3_stall", {31'd0, stall}, 1);
        @(negedge clk); chk("both_t4_addr", mem_addr, 32'h44);
                        chk("both_t4_en", {31'd0, mem_en}, 1);
        @(negedge clk); chk("both_t5_if_done", {31'd0, if_done}, 0);
        @(negedge clk); chk("both_t6_if_done", {31'd0, if_done}, 1);
                        chk("both_t6_if_rdata", if_rdata, 32'hFFFF0044);
                        chk("both_t6_stall", {31'd0, stall}, 0);
        #1 idle_inputs();

        // Store commits only in the last BUSY cycle.
        @(posedge clk); #1;
        dm_wr = 1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        chk("st_t1_we", {30'd0, mem_en, mem_we}, 32'd2);
        @(negedge clk); chk("st_t2_we", {31'd0, mem_we}, 1);
        @(negedge clk); chk("st_t3_done", {31'd0, dm_done}, 1);
                        chk("st_t3_we", {31'd0, mem_we}, 0);
        #1 idle_inputs();
        dir_rd(32'h200, rd_val);
        chk("st_readback", rd_val, 32'hDEADBEEF);

        // Reset during the commit cycle wins over the store.
        @(posedge clk); #1;
        dm_wr = 1; dm_addr = 32'h300; dm_wdata = 32'h12345678;
        @(posedge clk); @(posedge clk); #1 rst = 0;
        @(negedge clk); chk("abort_t2_we", {31'd0, mem_we}, 0);
        @(negedge clk);
        chk("abort_t3_en_done", {30'd0, mem_en, dm_done}, 0);
        chk("abort_t3_addr", mem_addr | mem_wdata, 0);
        chk("abort_t3_rdata", if_rdata | dm_rdata, 0);
        chk("abort_mem_untouched", {31'd0, dut_mem.exists(32'h300)}, 0);
        #1 idle_inputs(); rst = 1;
        dir_rd(32'h300, rd_val);
        chk("abort_readback", rd_val, 32'hFFFF0300);

        // rd+wr is a write; address changes during BUSY are ignored.
        @(posedge clk); #1;
        dm_rd = 1; dm_wr = 1; dm_addr = 32'h400; dm_wdata = 32'hCAFEF00D;
        @(posedge clk); #1 dm_addr = 32'h500; dm_wdata = '0;
        @(negedge clk); chk("rw_t1_addr", mem_addr, 32'h400);
        @(negedge clk); chk("rw_t2_we", {31'd0, mem_we}, 1);
                        chk("rw_t2_addr", mem_addr, 32'h400);
                        chk("rw_t2_wdata", mem_wdata, 32'hCAFEF00D);
        @(negedge clk); chk("rw_t3_done", {31'd0, dm_done}, 1);
        #1 idle_inputs();
        dir_rd(32'h400, rd_val);
        chk("rw_readback", rd_val, 32'hCAFEF00D);
        chk("rw_0x500_untouched", {31'd0, dut_mem.exists(32'h500)}, 0);

        // Random pipeline traffic over a small address window to force aliasing.
        @(posedge clk); #1;
        st_cnt = 0; mon_en = 1;
        repeat (200) begin
            int kind;
            bit fi, rd, wr;
            kind = $urandom_range(0, 2);
            fi = (kind != 1);
            rd = 0; wr = 0;
            if (kind != 0) begin
                case ($urandom_range(0, 3))
                    0, 1: rd = 1;
                    2:    wr = 1;
                    default: begin rd = 1; wr = 1; end
                endcase
            end
            issue(fi, rd, wr,
                  32'h1000 + 4 * $urandom_range(0, 7),
                  32'h1000 + 4 * $urandom_range(0, 7),
                  $urandom);
            #1 idle_inputs();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            @(posedge clk); #1;
        end
        @(negedge clk);
        mon_en = 0;
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("store_commit_count", we_cnt, n_stores);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
